// File: rtl/alu_pkg.sv
// Shared constants for the ALU result path: flag bit positions, op tags and
// a helper that packs the five status flags into their bus order.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    localparam int FLG_V   = 0;
    localparam int FLG_C   = 1;
    localparam int FLG_Z   = 2;
    localparam int FLG_N   = 3;
    localparam int FLG_B   = 4;
    localparam int FLAGS_W = 5;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    function automatic logic [FLAGS_W-1:0] pack_flags(
        input logic b,
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        logic [FLAGS_W-1:0] f;
        f        = {FLAGS_W{1'b0}};
        f[FLG_B] = b;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Generic synchronous FIFO with power-of-two depth, naturally wrapping
// pointers and an occupancy count one bit wider than the pointers.
module alu_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Guard the handshake so an overflow or underflow can never corrupt state.
    always_comb begin
        do_push_s = push & (count_r != CNT_FULL);
        do_pop_s  = pop & (count_r != {(AW+1){1'b0}});
    end

    // Pointer and occupancy bookkeeping; reset discards all contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push_s && !rst) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == CNT_FULL);
    assign empty = (count_r == {(AW+1){1'b0}});
    assign count = count_r;

endmodule

// File: rtl/alu_result_stage.sv
// Result stage behind the 4-bit adder/subtractor: derives N/Z/C/V/B flags,
// keeps the accumulator, sticky overflow and op counter, and queues results.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_m,
    input  logic [WIDTH-1:0]   in_s,
    input  logic               in_c,
    input  logic               in_v,
    output logic [WIDTH-1:0]   acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_s,
    output logic [FLAGS_W-1:0] out_flags,
    output logic               out_m,
    output logic               sticky_v,
    input  logic               clr_sticky,
    output logic [CNTW-1:0]    op_count
);

    localparam int ENTRY_W = WIDTH + FLAGS_W + 1;
    localparam int AW      = $clog2(DEPTH);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1'b1);

    logic [FLAGS_W-1:0] flags_s;
    logic [ENTRY_W-1:0] entry_s;
    logic [ENTRY_W-1:0] head_raw_s;
    logic [ENTRY_W-1:0] head_s;
    logic               full_s;
    logic               empty_s;
    logic [AW:0]        count_s;
    logic               accept_s;
    logic               pop_s;
    logic [WIDTH-1:0]   acc_r;
    logic               sticky_r;
    logic [CNTW-1:0]    op_count_r;

    // Flags from the raw adder outputs; borrow is only meaningful on subtract.
    always_comb begin
        flags_s = pack_flags((in_m == OP_SUB) & ~in_c,
                             in_s[WIDTH-1],
                             (in_s == {WIDTH{1'b0}}),
                             in_c,
                             in_v);
        entry_s = {in_s, flags_s, in_m};
    end

    // Handshakes: in_ready depends only on occupancy, never on out_ready.
    always_comb begin
        in_ready  = ~full_s & ~rst;
        out_valid = (count_s != {(AW+1){1'b0}}) & ~rst;
        accept_s  = in_valid & in_ready;
        pop_s     = out_valid & out_ready;
    end

    alu_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept_s),
        .wdata (entry_s),
        .pop   (pop_s),
        .rdata (head_raw_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Head fields read as zero whenever nothing is queued.
    always_comb begin
        if (empty_s) begin
            head_s = {ENTRY_W{1'b0}};
        end else begin
            head_s = head_raw_s;
        end
    end

    assign out_s     = head_s[ENTRY_W-1 -: WIDTH];
    assign out_flags = head_s[FLAGS_W:1];
    assign out_m     = head_s[0];

    // Accumulator, op counter and sticky overflow; a set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= {WIDTH{1'b0}};
            op_count_r <= {CNTW{1'b0}};
            sticky_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                acc_r      <= in_s;
                op_count_r <= op_count_r + CNT_ONE;
            end
            if (accept_s && in_v) begin
                sticky_r <= 1'b1;
            end else if (clr_sticky) begin
                sticky_r <= 1'b0;
            end else begin
                sticky_r <= sticky_r;
            end
        end
    end

    assign acc      = acc_r;
    assign sticky_v = sticky_r;
    assign op_count = op_count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: the driver queues hand-computed
// results, a negedge monitor checks every popped head against that queue.
module tb_alu_result_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_m;
    logic [3:0] in_s;
    logic       in_c;
    logic       in_v;
    logic [3:0] acc;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_s;
    logic [4:0] out_flags;
    logic       out_m;
    logic       sticky_v;
    logic       clr_sticky;
    logic [7:0] op_count;

    int n_cmp;
    int n_err;
    logic [9:0] exp_q[$];

    alu_result_stage #(.WIDTH(4), .DEPTH(2), .CNTW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_m       (in_m),
        .in_s       (in_s),
        .in_c       (in_c),
        .in_v       (in_v),
        .acc        (acc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_flags  (out_flags),
        .out_m      (out_m),
        .sticky_v   (sticky_v),
        .clr_sticky (clr_sticky),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one vector; queue its expected head only if it should be taken.
    task automatic push_vec(input logic m, input logic [3:0] s, input logic c, input logic v,
                            input logic [4:0] flags, input logic take);
        in_valid = 1'b1;
        in_m     = m;
        in_s     = s;
        in_c     = c;
        in_v     = v;
        chk("in_ready", {31'd0, in_ready}, {31'd0, take});
        if (take) exp_q.push_back({s, flags, m});
    endtask

    // Monitor: every head consumed by the pop at the coming edge is scored.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got %0h expected none", {out_s, out_flags, out_m});
            end else begin
                chk("head", {22'd0, out_s, out_flags, out_m}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; in_valid = 1'b0; in_m = 1'b0; in_s = 4'h0; in_c = 1'b0; in_v = 1'b0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_acc", {28'd0, acc}, 32'd0);
        chk("reset_cnt", {24'd0, op_count}, 32'd0);
        chk("reset_sticky", {31'd0, sticky_v}, 32'd0);
        chk("reset_out_s", {28'd0, out_s}, 32'd0);
        chk("reset_ready", {31'd0, in_ready}, 32'd1);

        // 1: add 5+3 with overflow
        push_vec(1'b1, 4'h8, 1'b0, 1'b1, 5'b01001, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_out_s", {28'd0, out_s}, 32'd8);
        chk("t1_flags", {27'd0, out_flags}, 32'b01001);
        chk("t1_acc", {28'd0, acc}, 32'd8);
        chk("t1_sticky", {31'd0, sticky_v}, 32'd1);
        chk("t1_cnt", {24'd0, op_count}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t1_drained", {31'd0, out_valid}, 32'd0);
        chk("t1_empty_flags", {27'd0, out_flags}, 32'd0);

        // 2: subtract cases (zero result, then borrow)
        push_vec(1'b0, 4'h0, 1'b1, 1'b0, 5'b00110, 1'b1);
        tick();
        push_vec(1'b0, 4'hF, 1'b0, 1'b0, 5'b11000, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t2_cnt", {24'd0, op_count}, 32'd3);
        chk("t2_acc", {28'd0, acc}, 32'hF);

        // 3: backpressure, third entry held by upstream until space frees
        out_ready = 1'b0;
        push_vec(1'b1, 4'h1, 1'b0, 1'b0, 5'b00000, 1'b1);
        tick();
        push_vec(1'b1, 4'h2, 1'b0, 1'b0, 5'b00000, 1'b1);
        tick();
        push_vec(1'b1, 4'h3, 1'b0, 1'b0, 5'b00000, 1'b0);
        tick();
        chk("t3_hold_s", {28'd0, out_s}, 32'd1);
        chk("t3_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        push_vec(1'b1, 4'h3, 1'b0, 1'b0, 5'b00000, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t3_cnt", {24'd0, op_count}, 32'd6);
        chk("t3_empty", {31'd0, out_valid}, 32'd0);

        // 4: full with both sides active; pop first, then push+pop together
        out_ready = 1'b0;
        push_vec(1'b1, 4'h4, 1'b0, 1'b0, 5'b00000, 1'b1);
        tick();
        push_vec(1'b1, 4'h5, 1'b0, 1'b0, 5'b00000, 1'b1);
        tick();
        out_ready = 1'b1;
        push_vec(1'b0, 4'h6, 1'b1, 1'b0, 5'b00010, 1'b0);
        tick();
        push_vec(1'b0, 4'h6, 1'b1, 1'b0, 5'b00010, 1'b1);
        tick();
        push_vec(1'b0, 4'h7, 1'b0, 1'b1, 5'b10001, 1'b1);
        tick();
        chk("t4_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        tick();
        tick();
        chk("t4_cnt", {24'd0, op_count}, 32'd10);
        chk("t4_acc", {28'd0, acc}, 32'd7);

        // 5: sticky set beats clear, then clear alone
        clr_sticky = 1'b1;
        push_vec(1'b1, 4'h9, 1'b1, 1'b1, 5'b01011, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t5_set_wins", {31'd0, sticky_v}, 32'd1);
        tick();
        clr_sticky = 1'b0;
        chk("t5_cleared", {31'd0, sticky_v}, 32'd0);
        tick();

        // 6: reset while two entries are queued and an input is offered
        out_ready = 1'b0;
        push_vec(1'b1, 4'hA, 1'b0, 1'b1, 5'b01001, 1'b1);
        tick();
        push_vec(1'b0, 4'hB, 1'b1, 1'b0, 5'b01010, 1'b1);
        tick();
        in_s = 4'hC;
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        tick();
        exp_q.delete();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_acc", {28'd0, acc}, 32'd0);
        chk("t6_cnt", {24'd0, op_count}, 32'd0);
        chk("t6_sticky", {31'd0, sticky_v}, 32'd0);

        // Fresh transaction after reset
        out_ready = 1'b1;
        push_vec(1'b1, 4'h0, 1'b1, 1'b0, 5'b00110, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("post_cnt", {24'd0, op_count}, 32'd1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
